// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: controller state encoding and the
// forward/inverse circulant matrix rows, one 32-bit word per row (column 0 in the MSB).
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mix_state_e;

   localparam logic [31:0] MIX_FWD_ROW0 = 32'h02030101;
   localparam logic [31:0] MIX_FWD_ROW1 = 32'h01020301;
   localparam logic [31:0] MIX_FWD_ROW2 = 32'h01010203;
   localparam logic [31:0] MIX_FWD_ROW3 = 32'h03010102;

   localparam logic [31:0] MIX_INV_ROW0 = 32'h0e0b0d09;
   localparam logic [31:0] MIX_INV_ROW1 = 32'h090e0b0d;
   localparam logic [31:0] MIX_INV_ROW2 = 32'h0d090e0b;
   localparam logic [31:0] MIX_INV_ROW3 = 32'h0b0d090e;

   function automatic logic [31:0] mix_row(input logic inv, input logic [1:0] idx);
      logic [31:0] row;
      row = MIX_FWD_ROW0;
      case ({inv, idx})
         3'b000:  row = MIX_FWD_ROW0;
         3'b001:  row = MIX_FWD_ROW1;
         3'b010:  row = MIX_FWD_ROW2;
         3'b011:  row = MIX_FWD_ROW3;
         3'b100:  row = MIX_INV_ROW0;
         3'b101:  row = MIX_INV_ROW1;
         3'b110:  row = MIX_INV_ROW2;
         default: row = MIX_INV_ROW3;
      endcase
      return row;
   endfunction

endpackage

// File: rtl/final_mix.sv
// One output row of (Inv)MixColumns: a 4-coefficient matrix row times the
// 4x4 byte state over GF(2^8), producing the four bytes of that result row.
module final_mix (
   input  logic [31:0]  coef_i,
   input  logic [127:0] state_i,
   output logic [31:0]  row_o
);

   function automatic logic [7:0] gmul(input logic [7:0] c, input logic [7:0] a);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int b = 0; b < 8; b++) begin
         if (c[b]) acc = acc ^ p;
         p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Column gi of the result row; state row k occupies bits [127-32k -: 32].
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_col
         assign row_o[31-8*gi -: 8] = gmul(coef_i[31:24], state_i[127-8*gi -: 8])
                                    ^ gmul(coef_i[23:16], state_i[95-8*gi  -: 8])
                                    ^ gmul(coef_i[15:8],  state_i[63-8*gi  -: 8])
                                    ^ gmul(coef_i[7:0],   state_i[31-8*gi  -: 8]);
      end
   endgenerate

endmodule

// File: rtl/mix_ctrl.sv
// Handshaked (Inv)MixColumns engine: latches a state, evaluates ROWS_PER_CYCLE
// result rows per RUN cycle through final_mix instances, then holds the result.
module mix_ctrl
   import aes_pkg::*;
#(
   parameter int ROWS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam logic [1:0] ROW_STEP = 2'(ROWS_PER_CYCLE);
   localparam logic [1:0] LAST_ROW = 2'(4 - ROWS_PER_CYCLE);

   mix_state_e   state_q, state_d;
   logic [1:0]   row_q, row_d;
   logic [127:0] data_q;
   logic         inv_q;
   logic [127:0] out_q, out_d;
   logic         accept;
   logic         step;

   logic [31:0]  coef    [ROWS_PER_CYCLE];
   logic [31:0]  row_res [ROWS_PER_CYCLE];

   generate
      for (genvar gi = 0; gi < ROWS_PER_CYCLE; gi++) begin : g_row
         assign coef[gi] = mix_row(inv_q, row_q + 2'(gi));
         final_mix u_final_mix (
            .coef_i  (coef[gi]),
            .state_i (data_q),
            .row_o   (row_res[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)          state_d = ST_RUN;
         ST_RUN:  if (row_q == LAST_ROW) state_d = ST_DONE;
         ST_DONE: if (out_ready)         state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      accept    = in_ready & in_valid;
      step      = (state_q == ST_RUN);
   end

   // Result words land at their row position; word i sits at bits [32*(3-i) +: 32].
   always_comb begin
      logic [1:0] idx;
      idx   = 2'd0;
      out_d = out_q;
      row_d = row_q;
      if (accept) begin
         row_d = 2'd0;
      end else if (step) begin
         row_d = row_q + ROW_STEP;
         for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            idx = row_q + 2'(k);
            out_d[{~idx, 5'b00000} +: 32] = row_res[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         inv_q  <= 1'b0;
         row_q  <= 2'd0;
         out_q  <= '0;
      end else begin
         if (accept) begin
            data_q <= in_state;
            inv_q  <= in_inv;
         end
         row_q <= row_d;
         out_q <= out_d;
      end
   end

   assign out_state = out_q;

endmodule

// File: tb/tb_mix_ctrl.sv
// Bench for mix_ctrl: two instances (1 and 4 rows per cycle) share stimulus, selected by sel.
module tb_mix_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         sel;
   logic         in_valid, in_inv, out_ready;
   logic [127:0] in_state;

   logic         in_valid_a, out_ready_a, in_ready_a, out_valid_a, busy_a;
   logic         in_valid_b, out_ready_b, in_ready_b, out_valid_b, busy_b;
   logic [127:0] out_state_a, out_state_b;

   logic         in_ready, out_valid, busy;
   logic [127:0] out_state;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign in_valid_a  = in_valid  & ~sel;
   assign out_ready_a = out_ready & ~sel;
   assign in_valid_b  = in_valid  & sel;
   assign out_ready_b = out_ready & sel;
   assign in_ready  = sel ? in_ready_b  : in_ready_a;
   assign out_valid = sel ? out_valid_b : out_valid_a;
   assign busy      = sel ? busy_b      : busy_a;
   assign out_state = sel ? out_state_b : out_state_a;

   mix_ctrl #(.ROWS_PER_CYCLE(1)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_state(in_state), .in_inv(in_inv),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_state(out_state_a), .busy(busy_a)
   );

   mix_ctrl #(.ROWS_PER_CYCLE(4)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_state(in_state), .in_inv(in_inv),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_state(out_state_b), .busy(busy_b)
   );

   // Reference: GF(2^8) product by shift-and-add, matrix as a circulant of its first row.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00; x = a; y = b;
      while (y != 8'h00) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
      logic [7:0]   base [4];
      logic [7:0]   sm   [4][4];
      logic [7:0]   acc;
      logic [127:0] r;
      if (inv) begin base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09; end
      else     begin base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01; end
      for (int i = 0; i < 4; i++)
         for (int c = 0; c < 4; c++)
            sm[i][c] = s[127 - 32*i - 8*c -: 8];
      r = '0;
      for (int i = 0; i < 4; i++)
         for (int c = 0; c < 4; c++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gf_mul(base[(k - i + 4) % 4], sm[k][c]);
            r[127 - 32*i - 8*c -: 8] = acc;
         end
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One transaction: accept, run with junk on the inputs, hold for `hold` cycles, release.
   task automatic xact(input logic [127:0] s, input logic inv, input int hold, input int exp_lat);
      logic [127:0] exp;
      int           lat;
      exp = ref_mix(s, inv);
      lat = 0;
      while (!in_ready && lat < 20) begin @(posedge clk); #1; lat++; end
      check("ready_before_accept", 128'(in_ready), 128'(1));
      in_state  = s;
      in_inv    = inv;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_state = rnd128();
      in_inv   = 1'($urandom);
      lat = 1;
      check("busy_after_accept", 128'(busy), 128'(1));
      while (!out_valid && lat < 30) begin
         in_valid = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 128'(lat), 128'(exp_lat));
      check("result", out_state, exp);
      for (int h = 0; h < hold; h++) begin
         in_valid = ~in_valid;
         in_state = rnd128();
         @(posedge clk); #1;
         check("hold_state", out_state, exp);
         check("hold_valid_ready", {out_valid, in_ready}, 128'(2'b10));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_handshake", {out_valid, in_ready, busy}, 128'(3'b010));
      check("release_retain", out_state, exp);
      out_ready = 1'b0;
   endtask

   logic [127:0] vec [3];
   logic [127:0] expq [$];
   int           acc_cyc [3];
   int           nacc, nout;
   logic         accepting;

   initial begin
      rst = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inv = 1'b0; in_state = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_flags_a", {out_valid_a, busy_a}, 128'(0));
      check("reset_state_a", out_state_a, 128'(0));
      check("reset_state_b", out_state_b, 128'(0));
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_reset", 128'(in_ready), 128'(1));

      xact(128'hdbdbdbdb_13131313_53535353_45454545, 1'b0, 0, 5);
      check("fwd_vector", out_state, 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc);
      xact(128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, 1'b1, 0, 5);
      check("inv_vector", out_state, 128'hdbdbdbdb_13131313_53535353_45454545);
      xact(128'hf2f2f2f2_0a0a0a0a_22222222_5c5c5c5c, 1'b0, 10, 5);
      check("backpressure_vector", out_state, 128'h9f9f9f9f_dcdcdcdc_58585858_9d9d9d9d);

      // Abort in the third RUN cycle.
      in_state = rnd128(); in_inv = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("abort_flags", {out_valid, busy}, 128'(0));
      check("abort_state", out_state, 128'(0));
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("abort_ready", {in_ready, out_valid}, 128'(2'b10));
      xact({4{32'hc6c6c6c6}}, 1'b0, 0, 5);
      check("after_abort_vector", out_state, {4{32'hc6c6c6c6}});

      // Streaming with in_valid and out_ready held high.
      for (int i = 0; i < 3; i++) vec[i] = rnd128();
      in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_state = vec[0];
      nacc = 0; nout = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         accepting = in_ready && in_valid;
         @(posedge clk); #1;
         if (accepting && nacc < 3) begin
            acc_cyc[nacc] = cyc;
            expq.push_back(ref_mix(vec[nacc], 1'b0));
            nacc++;
            if (nacc < 3) in_state = vec[nacc];
            else begin in_valid = 1'b0; in_state = rnd128(); end
         end
         if (out_valid) begin
            if (expq.size() > 0) check("stream_result", out_state, expq.pop_front());
            nout++;
         end
      end
      check("stream_count", 128'(nout), 128'(3));
      check("stream_gap1", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
      check("stream_gap2", 128'(acc_cyc[2] - acc_cyc[1]), 128'(6));
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++)
         xact(rnd128(), 1'($urandom), $urandom_range(0, 2), 5);

      // Four rows per cycle instance.
      sel = 1'b1;
      #1;
      xact(128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, 1'b1, 0, 2);
      check("inv_vector_x4", out_state, 128'hdbdbdbdb_13131313_53535353_45454545);
      for (int i = 0; i < 6; i++)
         xact(rnd128(), 1'($urandom), $urandom_range(0, 2), 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mix_ctrl.md
MIX_CTRL -- requirements
Module: mix_ctrl

Interface
REQ-001 SHALL have parameter ROWS_PER_CYCLE, default 1, giving the number of matrix rows evaluated per RUN cycle; legal values are 1 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream offers a state.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a state.
REQ-006 SHALL have port in_state, input, 128 bits: the AES state, row-major; [127:96] = row 0 and [127:120] = S[0][0].
REQ-007 SHALL have port in_inv, input, 1 bit: 0 selects MixColumns, 1 selects InvMixColumns.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream takes the result.
REQ-010 SHALL have port out_state, output, 128 bits: the result, in the same layout as in_state.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL drive in_ready = (state == IDLE), combinationally from the state register only.
REQ-014 SHALL, on an edge with in_valid & in_ready: latch in_state and in_inv, clear row counter, go IDLE->RUN.
REQ-015 SHALL ignore in_state and in_inv after acceptance until the next acceptance.
REQ-016 SHALL, in RUN, per edge, compute result row(s) = matrix row i x latched state over GF(2^8), and write them into out_state word(s) i.
REQ-017 SHALL use forward matrix rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
REQ-018 SHALL use inverse matrix rows {0E 0B 0D 09}, {09 0E 0B 0D}, {0D 09 0E 0B}, {0B 0D 09 0E}.
REQ-019 SHALL spend 4/ROWS_PER_CYCLE RUN cycles; the row counter increments by ROWS_PER_CYCLE and wraps to 0.
REQ-020 SHALL go RUN->DONE on the edge writing row 3, so out_valid rises 1+4/ROWS_PER_CYCLE edges after the accept edge (5 for ROWS_PER_CYCLE=1, 2 for ROWS_PER_CYCLE=4).
REQ-021 SHALL drive out_valid = (state == DONE) and hold out_state stable while out_valid is high.
REQ-022 SHALL go DONE->IDLE on an edge with out_ready high; out_state retains its value afterwards.
REQ-023 SHALL NOT accept a new state in the same cycle that a result is released; back-to-back throughput is one state per 2+4/ROWS_PER_CYCLE cycles.
REQ-024 SHALL ignore in_valid in RUN and DONE, and ignore out_ready in IDLE and RUN.
REQ-025 SHALL be legal to hold out_ready permanently high; DONE then lasts exactly one cycle.

Reset
REQ-026 SHALL, while rst is high, force state=IDLE, row counter=0, out_state=0, latched state=0 and latched inv=0, giving out_valid=0 and busy=0.
REQ-027 SHALL, on rst asserted mid-RUN or in DONE, abort immediately and discard any partial result, with no output pulse.
REQ-028 SHALL assert in_ready from the first clock edge after rst deasserts.

Structure
REQ-029 SHALL place the state encoding and the forward/inverse matrix row constants (8 x 32 bits) in shared package aes_pkg.
REQ-030 SHALL instantiate ROWS_PER_CYCLE copies of the existing final_mix sub-module (row x 4 columns -> 32-bit row), fed with the selected matrix row and the latched state.
REQ-031 SHALL contain no GF(2^8) multiply logic of its own.

Verification
REQ-032 Forward test: in_state = dbdbdbdb_13131313_53535353_45454545, in_inv=0 -> out_state = 8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, out_valid exactly 5 edges after accept.
REQ-033 Inverse test: in_state = 8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, in_inv=1 -> out_state = dbdbdbdb_13131313_53535353_45454545; repeat with ROWS_PER_CYCLE=4 -> same value, 2-edge latency.
REQ-034 Backpressure test: state f2f2f2f2_0a0a0a0a_22222222_5c5c5c5c, out_ready low 10 cycles -> out_state stable at 9f9f9f9f_dcdcdcdc_58585858_9d9d9d9d, in_ready=0 throughout, in_valid toggling ignored.
REQ-035 Abort test: rst pulsed in the 3rd RUN cycle -> out_valid=0, out_state=0, in_ready=1 next edge; next state c6c6c6c6 in all rows -> c6c6c6c6 in all rows.
REQ-036 Throughput test: in_valid and out_ready held high with 3 streamed states -> results in order, one accept every 6 cycles (ROWS_PER_CYCLE=1); inputs changed after accept have no effect.
